puf_authenticator: RTL
======================

# puf_authenticator

Host-side controller for the 8-bit ring-oscillator PUF response generator. It triggers a measurement with a one-cycle `puf_en` pulse and captures the 8-bit response on the rising edge of `puf_valid`. In enrollment it majority-votes `RUNS` responses into a stored golden response. In verification it takes one response, computes its Hamming distance to the golden value, and reports pass/fail.

## Interface
- `RUNS`, 5: enrollment repetitions; odd, 1..15.
- `HD_MAX`, 1: maximum Hamming distance accepted as pass; 0..8.
- `TIMEOUT`, 32'h000F_FFFF: cycles allowed in WAIT per measurement.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `enroll` in 1: start enrollment; sampled only in IDLE.
- `verify` in 1: start verification; sampled only in IDLE.
- `puf_en` out 1: one-cycle measurement request to the PUF.
- `puf_valid` in 1: PUF response valid, level signal; only its rising edge is used.
- `puf_response` in 8: PUF response; sampled on the `puf_valid` rising edge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of each command.
- `pass` out 1: verification result; held until the next `done`.
- `hd` out 4: Hamming distance of the last verification (0..8); held.
- `timeout` out 1: the last command aborted on timeout; held.
- `enrolled` out 1: a golden response is stored.

## Operation
- States: IDLE, REQ, WAIT, ACCUM, DECIDE, RESULT.
- IDLE:
  - `enroll`=1 → REQ in enroll mode. If `verify` is also 1, enroll wins.
  - `verify`=1 with `enrolled`=1 → REQ in verify mode.
  - `verify`=1 with `enrolled`=0 → RESULT with `pass`=0, `hd`=8, `timeout`=0; no `puf_en` is issued.
- REQ: `puf_en`=1 for exactly this cycle. Clear the timeout counter. → WAIT.
- WAIT:
  - Rising edge is `puf_valid`=1 with `valid_q`=0, where `valid_q` is the registered previous `puf_valid`.
  - On the edge: latch `puf_response` into `resp_q` → ACCUM.
  - A `puf_valid` level left high from an earlier run is never captured.
  - If the counter reaches `TIMEOUT` first → RESULT with `timeout`=1 and `pass`=0. The golden register, vote counters and `enrolled` are unchanged.
- ACCUM:
  - Enroll mode: per bit, `ones[i]` += `resp_q[i]` (eight 4-bit counters); `run` += 1. If `run` < `RUNS` → REQ, else → DECIDE.
  - Verify mode: → DECIDE.
- DECIDE:
  - Enroll mode: `golden[i]` = (`ones[i]` > `RUNS`/2); `enrolled` ← 1; `pass` ← 1; `hd` ← 0.
  - Verify mode: `hd` ← popcount(`resp_q` ^ `golden`); `pass` ← (`hd` ≤ `HD_MAX`).
  - Clear `timeout`. → RESULT.
- RESULT: `done`=1 for this cycle. Clear `ones` and `run`. → IDLE.
- `enroll`/`verify` while `busy` are ignored, not queued.
- Re-enrollment overwrites `golden` only if it completes without timeout.

## Timing
- Reset values: IDLE; `puf_en`, `busy`, `done`, `pass`, `timeout`, `enrolled` = 0; `hd`, `golden`, `resp_q`, `ones`, `run`, `valid_q` = 0.
- A reset mid-command aborts with no `done` and clears `enrolled`.
- Command accepted at cycle N → `puf_en` high at N+1; `busy` high from N+1.
- Valid edge seen at cycle E:
  - ACCUM at E+1.
  - Next `puf_en` at E+2, if more enrollment runs remain.
  - Otherwise DECIDE at E+2 and `done` at E+3, with `pass`/`hd` already updated that cycle.
- Verify without enrollment: command at N → `done` at N+1.
- Timeout: `done` exactly `TIMEOUT`+1 cycles after `puf_en`.
- `busy` falls the cycle after `done`. A new command is accepted the cycle after `done`.

## Test plan
- Reset, then `verify` pulse → `done` 1 cycle later, `pass`=0, `hd`=8, `puf_en` never asserted.
- `RUNS`=3, PUF model returns 0xA5, 0xA4, 0x25 → three `puf_en` pulses, `golden`=0xA5, `enrolled`=1, `done` 3 cycles after the third valid edge.
- `HD_MAX`=1 after the enroll above:
  - 0xA5 → `hd`=0, `pass`=1.
  - 0xA7 → `hd`=1, `pass`=1.
  - 0xA6 → `hd`=2, `pass`=0.
  - 0x5A → `hd`=8, `pass`=0.
- `TIMEOUT`=100, model never raises valid, during re-enrollment → `done` 101 cycles after `puf_en`, `timeout`=1, `golden` still 0xA5, `enrolled`=1.
- Model holds `puf_valid` high from the prior run, then drops it for 2 cycles and raises it with 0x3C → only 0x3C is captured.
- `enroll`+`verify` in the same cycle → enrollment runs; `verify` pulsed mid-run is ignored; `rst` mid-enrollment → IDLE, `enrolled`=0, no `done`.

Source files
------------

// File: rtl/puf_authenticator_if.sv
// Signal bundle between the PUF authenticator and its environment.
// The host command/status lines and the PUF measurement handshake travel
// together; the authenticator is the slave side, the environment the master.
interface puf_authenticator_if;
    logic       enroll;
    logic       verify;
    logic       puf_en;
    logic       puf_valid;
    logic [7:0] puf_response;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] hd;
    logic       timeout;
    logic       enrolled;

    modport master (
        output enroll,
        output verify,
        output puf_valid,
        output puf_response,
        input  puf_en,
        input  busy,
        input  done,
        input  pass,
        input  hd,
        input  timeout,
        input  enrolled
    );

    modport slave (
        input  enroll,
        input  verify,
        input  puf_valid,
        input  puf_response,
        output puf_en,
        output busy,
        output done,
        output pass,
        output hd,
        output timeout,
        output enrolled
    );
endinterface

// File: rtl/puf_authenticator.sv
// Host-side controller for an 8-bit ring-oscillator PUF.
// Enrollment majority-votes RUNS responses into a golden value; verification
// takes a single response and scores it by Hamming distance to that golden
// value. Every status output is driven straight from a register.
module puf_authenticator #(
    parameter int unsigned RUNS    = 5,
    parameter int unsigned HD_MAX  = 1,
    parameter logic [31:0] TIMEOUT = 32'h000F_FFFF
) (
    input logic                clk,
    input logic                rst,
    puf_authenticator_if.slave bus
);

    // Parameters narrowed to the widths of the counters they are compared with.
    localparam logic [3:0]  RUNS_L      = 4'(RUNS);
    localparam logic [3:0]  HALF_RUNS_L = 4'(RUNS / 32'd2);
    localparam logic [3:0]  HD_MAX_L    = 4'(HD_MAX);
    // Last WAIT cycle index: WAIT lasts at most TIMEOUT cycles per measurement.
    localparam logic [31:0] WAIT_LAST_L = TIMEOUT - 32'd1;

    // Number of set bits in a byte (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_DECIDE = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    // Datapath state
    logic            valid_q_r;
    logic [7:0]      resp_q_r;
    logic [7:0]      golden_r;
    logic [7:0][3:0] ones_r;
    logic [3:0]      run_r;
    logic [31:0]     wait_cnt_r;
    logic            mode_enroll_r;

    // Registered outputs
    logic            puf_en_r;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
    logic [3:0]      hd_r;
    logic            timeout_r;
    logic            enrolled_r;

    // Decoded events from the next-state logic
    logic            start_enroll_s;
    logic            start_verify_s;
    logic            no_golden_s;
    logic            capture_s;
    logic            abort_s;

    // Combinational helpers
    logic            rise_s;
    logic            expire_s;
    logic [3:0]      run_inc_s;
    logic [3:0]      hd_s;
    logic [7:0]      majority_s;

    // Only a fresh low-to-high transition counts; a level held over from a
    // previous measurement never produces a capture.
    assign rise_s    = bus.puf_valid & ~valid_q_r;
    assign expire_s  = (wait_cnt_r == WAIT_LAST_L);
    assign run_inc_s = run_r + 4'd1;
    assign hd_s      = popcount8(resp_q_r ^ golden_r);

    // Per-bit majority of the enrollment vote counters.
    always_comb begin
        majority_s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            majority_s[i] = (ones_r[i] > HALF_RUNS_L);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and command/measurement event flags.
    always_comb begin
        state_next_s   = state_r;
        start_enroll_s = 1'b0;
        start_verify_s = 1'b0;
        no_golden_s    = 1'b0;
        capture_s      = 1'b0;
        abort_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.enroll) begin
                    // Enrollment takes priority over a simultaneous verify.
                    start_enroll_s = 1'b1;
                    state_next_s   = ST_REQ;
                end else if (bus.verify) begin
                    if (enrolled_r) begin
                        start_verify_s = 1'b1;
                        state_next_s   = ST_REQ;
                    end else begin
                        // Nothing to compare against: fail without measuring.
                        no_golden_s  = 1'b1;
                        state_next_s = ST_RESULT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (rise_s) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_ACCUM;
                end else if (expire_s) begin
                    abort_s      = 1'b1;
                    state_next_s = ST_RESULT;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ACCUM: begin
                if (mode_enroll_r && (run_inc_s < RUNS_L)) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                state_next_s = ST_RESULT;
            end
            ST_RESULT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Strobe outputs registered from the upcoming state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            puf_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            puf_en_r <= (state_next_s == ST_REQ);
            busy_r   <= (state_next_s != ST_IDLE);
            done_r   <= (state_next_s == ST_RESULT);
        end
    end

    // Measurement capture, vote accumulation, golden storage and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q_r     <= 1'b0;
            resp_q_r      <= 8'd0;
            golden_r      <= 8'd0;
            ones_r        <= '0;
            run_r         <= 4'd0;
            wait_cnt_r    <= 32'd0;
            mode_enroll_r <= 1'b0;
            pass_r        <= 1'b0;
            hd_r          <= 4'd0;
            timeout_r     <= 1'b0;
            enrolled_r    <= 1'b0;
        end else begin
            valid_q_r <= bus.puf_valid;
            case (state_r)
                ST_IDLE: begin
                    if (start_enroll_s) begin
                        mode_enroll_r <= 1'b1;
                    end else if (start_verify_s) begin
                        mode_enroll_r <= 1'b0;
                    end else if (no_golden_s) begin
                        pass_r    <= 1'b0;
                        hd_r      <= 4'd8;
                        timeout_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    wait_cnt_r <= 32'd0;
                end
                ST_WAIT: begin
                    if (capture_s) begin
                        resp_q_r <= bus.puf_response;
                    end else if (abort_s) begin
                        // Golden value, votes and enrolled flag stay untouched.
                        timeout_r <= 1'b1;
                        pass_r    <= 1'b0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                ST_ACCUM: begin
                    if (mode_enroll_r) begin
                        for (int i = 0; i < 8; i++) begin
                            ones_r[i] <= ones_r[i] + {3'd0, resp_q_r[i]};
                        end
                        run_r <= run_inc_s;
                    end
                end
                ST_DECIDE: begin
                    if (mode_enroll_r) begin
                        golden_r   <= majority_s;
                        enrolled_r <= 1'b1;
                        pass_r     <= 1'b1;
                        hd_r       <= 4'd0;
                    end else begin
                        hd_r   <= hd_s;
                        pass_r <= (hd_s <= HD_MAX_L);
                    end
                    timeout_r <= 1'b0;
                end
                ST_RESULT: begin
                    ones_r <= '0;
                    run_r  <= 4'd0;
                end
                default: begin
                    ones_r <= '0;
                    run_r  <= 4'd0;
                end
            endcase
        end
    end

    assign bus.puf_en   = puf_en_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pass     = pass_r;
    assign bus.hd       = hd_r;
    assign bus.timeout  = timeout_r;
    assign bus.enrolled = enrolled_r;

endmodule
